mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 24 ++
 rtl/mem_responder_ram.sv | 24 ++
 rtl/mem_responder.sv | 152 +++++++++++++++
 tb/tb_mem_responder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the mem_responder burst responder: state encoding and default widths.
// BURST_WR exists only when MEM_RESPONDER_WRITE_EN is defined.
package mem_responder_pkg;

    localparam int unsigned DEF_WORD_WIDTH     = 32;
    localparam int unsigned DEF_ADR_WIDTH      = 32;
    localparam int unsigned DEF_WORD_NUM       = 4;
    localparam int unsigned DEF_MEM_WORDS_LOG2 = 12;
    localparam int unsigned DEF_LATENCY        = 3;

    // Latency counter width; LATENCY is limited to 1..15
    localparam int unsigned LAT_W = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT     = 3'd1,
        BURST_RD = 3'd2
`ifdef MEM_RESPONDER_WRITE_EN
        ,
        BURST_WR = 3'd3
`endif
    } state_t;

endpackage

// File: rtl/mem_responder_ram.sv
// Backing store for mem_responder: single-port word array, combinational read, synchronous write.
// Contents are deliberately not reset.
module mem_responder_ram #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned ADDR_W     = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [WORD_WIDTH-1:0] wdata,
    output logic [WORD_WIDTH-1:0] rdata
);

    logic [WORD_WIDTH-1:0] mem [0:(1 << ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Cache-line memory responder: fixed-latency bursts, critical word first with wrap inside the line.
// Write-back beats are compiled in only when MEM_RESPONDER_WRITE_EN is defined.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned WORD_WIDTH     = DEF_WORD_WIDTH,
    parameter int unsigned ADR_WIDTH      = DEF_ADR_WIDTH,
    parameter int unsigned WORD_NUM       = DEF_WORD_NUM,
    parameter int unsigned MEM_WORDS_LOG2 = DEF_MEM_WORDS_LOG2,
    parameter int unsigned LATENCY        = DEF_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_req_i,
    input  logic [ADR_WIDTH-1:0]  mem_adr_i,
    input  logic                  mem_rdwr_i,
    input  logic [WORD_WIDTH-1:0] mem_dat_i,
    output logic                  mem_ack_o,
    output logic [WORD_WIDTH-1:0] mem_dat_o
);

    localparam int unsigned      OFS_W     = $clog2(WORD_NUM);
    localparam int unsigned      LINE_W    = MEM_WORDS_LOG2 - OFS_W;
    localparam logic [OFS_W-1:0] LAST_BEAT = OFS_W'(WORD_NUM - 1);
    localparam logic [LAT_W-1:0] LAT_LOAD  = LAT_W'(LATENCY - 1);

    state_t                    state_q, state_d;
    state_t                    burst_state;
    logic [LAT_W-1:0]          cnt_q, cnt_d;
    logic [OFS_W-1:0]          beat_q, beat_d;
    logic [OFS_W-1:0]          start_q, start_d;
    logic [LINE_W-1:0]         line_q, line_d;
    logic                      rdwr_q, rdwr_d;
    logic                      ack_q, ack_d;
    logic                      gap_q, gap_d;
    logic [OFS_W-1:0]          ofs;
    logic [MEM_WORDS_LOG2-1:0] ram_addr;
    logic [WORD_WIDTH-1:0]     ram_rdata;
    logic [WORD_WIDTH-1:0]     ram_wdata;
    logic                      ram_we;
    logic                      unused_inputs;

`ifdef MEM_RESPONDER_WRITE_EN
    assign burst_state   = rdwr_q ? BURST_WR : BURST_RD;
    assign ram_we        = (state_q == BURST_WR) && mem_req_i && !rst;
    assign ram_wdata     = mem_dat_i;
    assign unused_inputs = ^{mem_adr_i[ADR_WIDTH-1:MEM_WORDS_LOG2+2], mem_adr_i[1:0]};
`else
    // Write-back requests run with read timing; the array is never written
    assign burst_state   = BURST_RD;
    assign ram_we        = 1'b0;
    assign ram_wdata     = '0;
    assign unused_inputs = ^{mem_adr_i[ADR_WIDTH-1:MEM_WORDS_LOG2+2], mem_adr_i[1:0],
                             mem_dat_i, rdwr_q};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            start_q <= '0;
            line_q  <= '0;
            rdwr_q  <= 1'b0;
            ack_q   <= 1'b0;
            gap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            start_q <= start_d;
            line_q  <= line_d;
            rdwr_q  <= rdwr_d;
            ack_q   <= ack_d;
            gap_q   <= gap_d;
        end
    end

    // ack_d is raised exactly when the next state is a burst, so mem_ack_o is a plain flop
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        start_d = start_q;
        line_d  = line_q;
        rdwr_d  = rdwr_q;
        ack_d   = 1'b0;
        gap_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_req_i && !gap_q) begin
                    line_d  = mem_adr_i[MEM_WORDS_LOG2+1:OFS_W+2];
                    start_d = mem_adr_i[OFS_W+1:2];
                    rdwr_d  = mem_rdwr_i;
                    cnt_d   = LAT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!mem_req_i) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    beat_d  = '0;
                    ack_d   = 1'b1;
                    state_d = burst_state;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef MEM_RESPONDER_WRITE_EN
            BURST_RD, BURST_WR: begin
`else
            BURST_RD: begin
`endif
                if (!mem_req_i) begin
                    beat_d  = '0;
                    state_d = IDLE;
                end else if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    gap_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    beat_d = beat_q + 1'b1;
                    ack_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Beat offset wraps naturally in OFS_W bits
    assign ofs      = start_q + beat_q;
    assign ram_addr = {line_q, ofs};

    mem_responder_ram #(
        .WORD_WIDTH(WORD_WIDTH),
        .ADDR_W    (MEM_WORDS_LOG2)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    assign mem_ack_o = ack_q;
    assign mem_dat_o = (ack_q && (state_q == BURST_RD)) ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder against an array model of the backing store.
// Write-back expectations follow MEM_RESPONDER_WRITE_EN.
module tb_mem_responder;

    localparam int unsigned WN        = 4;
    localparam int unsigned LAT       = 3;
    localparam int unsigned MEM_WORDS = 4096;
`ifdef MEM_RESPONDER_WRITE_EN
    localparam bit WR_EN = 1'b1;
`else
    localparam bit WR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        mem_req_i;
    logic [31:0] mem_adr_i;
    logic        mem_rdwr_i;
    logic [31:0] mem_dat_i;
    logic        mem_ack_o;
    logic [31:0] mem_dat_o;

    logic [31:0] model [MEM_WORDS];
    logic [31:0] wbeat [WN];
    int          checks;
    int          errors;

    mem_responder #(
        .WORD_WIDTH    (32),
        .ADR_WIDTH     (32),
        .WORD_NUM      (WN),
        .MEM_WORDS_LOG2(12),
        .LATENCY       (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req_i (mem_req_i),
        .mem_adr_i (mem_adr_i),
        .mem_rdwr_i(mem_rdwr_i),
        .mem_dat_i (mem_dat_i),
        .mem_ack_o (mem_ack_o),
        .mem_dat_o (mem_dat_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Word k of a burst: same line as adr, offset (critical word + k) mod WN
    function automatic int unsigned word_idx(input logic [31:0] adr, input int unsigned k);
        int unsigned line_no;
        int unsigned first;
        line_no = (adr / 16) % (MEM_WORDS / WN);
        first   = (adr / 4) % WN;
        return line_no * WN + (first + k) % WN;
    endfunction

    task automatic check_quiet(input string tag);
        checks++;
        if (mem_ack_o !== 1'b0 || mem_dat_o !== 32'h0) begin
            errors++;
            $display("FAIL %s: ack=%b dat=%h, required ack=0 dat=0", tag, mem_ack_o, mem_dat_o);
        end
    endtask

    // Starts in the acceptance cycle; drop_beat >= 0 lowers mem_req_i in that beat's cycle
    task automatic run_burst(input logic [31:0] adr, input logic rdwr, input int drop_beat,
                             input logic keep_req);
        int unsigned idx;
        logic        wr;
        wr         = rdwr && WR_EN;
        mem_req_i  = 1'b1;
        mem_adr_i  = adr;
        mem_rdwr_i = rdwr;
        mem_dat_i  = $urandom;
        step();
        mem_adr_i  = $urandom;
        mem_rdwr_i = 1'($urandom);
        mem_dat_i  = $urandom;
        for (int c = 1; c <= int'(LAT); c++) begin
            check_quiet("latency_gap");
            step();
        end
        for (int k = 0; k < int'(WN); k++) begin
            if (k == drop_beat) begin
                mem_req_i = 1'b0;
                mem_dat_i = $urandom;
                for (int j = 0; j < int'(WN) + 2; j++) begin
                    step();
                    check_quiet("after_abort");
                end
                return;
            end
            idx = word_idx(adr, k);
            checks++;
            if (mem_ack_o !== 1'b1) begin
                errors++;
                $display("FAIL beat_ack adr=%h beat %0d: ack=%b, required 1", adr, k, mem_ack_o);
            end
            if (!wr) begin
                checks++;
                if (mem_dat_o !== model[idx]) begin
                    errors++;
                    $display("FAIL beat_data adr=%h beat %0d: dat=%h, required %h",
                             adr, k, mem_dat_o, model[idx]);
                end
                mem_dat_i = $urandom;
            end else begin
                mem_dat_i  = wbeat[k];
                model[idx] = wbeat[k];
            end
            step();
        end
        mem_req_i = keep_req;
        check_quiet("idle_gap");
        step();
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        mem_req_i  = 1'b0;
        mem_adr_i  = '0;
        mem_rdwr_i = 1'b0;
        mem_dat_i  = '0;
        step();
        step();
        check_quiet("reset_state");
        rst = 1'b0;
        step();
        check_quiet("post_reset_idle");
    endtask

    task automatic test_critical_word();
        for (int i = 0; i < 4; i++) begin
            model['h40 + i]         = 32'hA000_0000 + 32'(i);
            dut.u_ram.mem['h40 + i] = 32'hA000_0000 + 32'(i);
        end
        run_burst(32'h0000_0108, 1'b0, -1, 1'b0);
    endtask

    task automatic test_write_back();
        logic [31:0] pre [4];
        logic [31:0] exp_w;
        int unsigned w;
        for (int i = 0; i < 4; i++) begin
            pre[i]   = model['h80 + i];
            wbeat[i] = $urandom;
        end
        run_burst(32'h0000_020C, 1'b1, -1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            w     = 'h80 + (3 + i) % 4;
            exp_w = WR_EN ? wbeat[i] : pre[(3 + i) % 4];
            checks++;
            if (dut.u_ram.mem[w] !== exp_w) begin
                errors++;
                $display("FAIL wb_store word %h: got %h, required %h", w, dut.u_ram.mem[w], exp_w);
            end
        end
        run_burst(32'h0000_0200, 1'b0, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_burst(32'h0000_0134, 1'b0, -1, 1'b1);
        run_burst(32'h0000_0A58, 1'b0, -1, 1'b1);
        for (int i = 0; i < 4; i++) wbeat[i] = $urandom;
        run_burst(32'h0000_0A50, 1'b1, -1, 1'b0);
    endtask

    task automatic test_abort();
        logic [31:0] adr;
        adr = {$urandom} & 32'hFFFF_FFF0 | 32'h4;
        for (int i = 0; i < 4; i++) wbeat[i] = $urandom;
        run_burst(adr, 1'b1, 2, 1'b0);
        run_burst(adr, 1'b0, -1, 1'b0);
        run_burst(32'h0000_0108, 1'b0, 2, 1'b0);
        // drop during the latency wait
        mem_req_i  = 1'b1;
        mem_adr_i  = 32'h0000_0300;
        mem_rdwr_i = 1'b0;
        step();
        step();
        mem_req_i = 1'b0;
        for (int j = 0; j < int'(LAT + WN) + 2; j++) begin
            step();
            check_quiet("wait_abort");
        end
    endtask

    task automatic test_reset_in_burst();
        mem_req_i  = 1'b1;
        mem_adr_i  = 32'h0000_0108;
        mem_rdwr_i = 1'b0;
        for (int c = 0; c < int'(LAT); c++) step();
        rst = 1'b1;
        step();
        check_quiet("reset_in_wait");
        rst       = 1'b0;
        mem_req_i = 1'b0;
        for (int j = 0; j < int'(LAT + WN) + 2; j++) begin
            step();
            check_quiet("after_wait_reset");
        end
        run_burst(32'h0000_0108, 1'b0, -1, 1'b0);
        mem_req_i = 1'b1;
        for (int c = 0; c <= int'(LAT) + 1; c++) step();
        rst = 1'b1;
        step();
        check_quiet("reset_in_burst");
        rst       = 1'b0;
        mem_req_i = 1'b0;
        for (int j = 0; j < int'(WN) + 1; j++) begin
            step();
            check_quiet("after_burst_reset");
        end
        // reset and request in the same cycle: request must be ignored
        rst        = 1'b1;
        mem_req_i  = 1'b1;
        mem_adr_i  = 32'h0000_0104;
        step();
        check_quiet("reset_priority");
        rst = 1'b0;
        run_burst(32'h0000_0104, 1'b0, -1, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] adr;
        logic        rdwr;
        logic        keep;
        for (int n = 0; n < 40; n++) begin
            adr  = $urandom;
            rdwr = 1'($urandom);
            keep = (n < 39) ? 1'($urandom) : 1'b0;
            for (int i = 0; i < 4; i++) wbeat[i] = $urandom;
            run_burst(adr, rdwr, -1, keep);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            model[i]         = $urandom;
            dut.u_ram.mem[i] = model[i];
        end
        test_reset();
        test_critical_word();
        test_write_back();
        test_back_to_back();
        test_abort();
        test_reset_in_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
